// File: rtl/smbus_responder.sv
// rtl/smbus_responder.sv - SMBus/I2C target with oversampled bus inputs and a 32x8 register file
module smbus_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h48,
  parameter int         FILT     = 3
) (
  input  logic       ap_clk,
  input  logic       ap_rst_n,
  input  logic       smb_scl,
  input  logic       smb_sda_in,
  output logic       smb_sda_oe,
  input  logic [4:0] loc_addr,
  output logic [7:0] loc_rd_data,
  output logic       wr_strobe,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam logic [2:0] FILT_C = 3'(FILT);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_PTR, S_ACK_P, S_WDATA, S_ACK_W, S_RDATA, S_RACK
  } state_t;

  logic [1:0] scl_s_q, sda_s_q;
  logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic [2:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic       scl_p_q, sda_p_q;

  state_t     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic [4:0] ptr_q, ptr_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [4:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       reg_we;
  logic [7:0] regs_q [32];
  logic [7:0] loc_rd_q;

  logic scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] rd_byte;

  assign scl_rise = scl_f_q & ~scl_p_q;
  assign scl_fall = ~scl_f_q & scl_p_q;
  assign start_c  = scl_f_q & sda_p_q & ~sda_f_q;
  assign stop_c   = scl_f_q & ~sda_p_q & sda_f_q;
  assign rd_byte  = regs_q[ptr_q];

  assign smb_sda_oe  = oe_q;
  assign loc_rd_data = loc_rd_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;

  // Two-flop synchronizers, preset to the idle-bus level
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      scl_s_q <= 2'b11;
      sda_s_q <= 2'b11;
    end else begin
      scl_s_q <= {scl_s_q[0], smb_scl};
      sda_s_q <= {sda_s_q[0], smb_sda_in};
    end
  end

  // Glitch filter: a level change needs FILT consecutive differing samples
  always_comb begin
    scl_cnt_d = '0;
    scl_f_d   = scl_f_q;
    sda_cnt_d = '0;
    sda_f_d   = sda_f_q;
    if (scl_s_q[1] != scl_f_q) begin
      if (scl_cnt_q + 3'd1 == FILT_C) scl_f_d = scl_s_q[1];
      else scl_cnt_d = scl_cnt_q + 3'd1;
    end
    if (sda_s_q[1] != sda_f_q) begin
      if (sda_cnt_q + 3'd1 == FILT_C) sda_f_d = sda_s_q[1];
      else sda_cnt_d = sda_cnt_q + 3'd1;
    end
  end

  // Filtered levels and their previous values for edge detection
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      scl_f_q   <= 1'b1;
      sda_f_q   <= 1'b1;
      scl_p_q   <= 1'b1;
      sda_p_q   <= 1'b1;
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
    end else begin
      scl_f_q   <= scl_f_d;
      sda_f_q   <= sda_f_d;
      scl_p_q   <= scl_f_q;
      sda_p_q   <= sda_f_q;
      scl_cnt_q <= scl_cnt_d;
      sda_cnt_q <= sda_cnt_d;
    end
  end

  // Protocol FSM: bits sampled on SCL rise, SDA drive changed only on SCL fall
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    ptr_d       = ptr_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_we      = 1'b0;
    if (start_c) begin
      state_d  = S_ADDR;
      bitcnt_d = '0;
      oe_d     = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_c) begin
      state_d  = S_IDLE;
      bitcnt_d = '0;
      oe_d     = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d  = {shift_q[6:0], sda_f_q};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            bitcnt_d = '0;
            if (state_q == S_ADDR) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                state_d = S_ACK_A;
                rw_d    = shift_q[0];
                oe_d    = 1'b1;
                busy_d  = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
            end else if (state_q == S_PTR) begin
              ptr_d   = shift_q[4:0];
              state_d = S_ACK_P;
              oe_d    = 1'b1;
            end else begin
              reg_we      = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = ptr_q;
              wr_data_d   = shift_q;
              ptr_d       = ptr_q + 5'd1;
              state_d     = S_ACK_W;
              oe_d        = 1'b1;
            end
          end
        end
        S_ACK_A: begin
          if (scl_fall) begin
            bitcnt_d = '0;
            if (rw_q) begin
              state_d = S_RDATA;
              shift_d = rd_byte;
              oe_d    = ~rd_byte[7];
            end else begin
              state_d = S_PTR;
              oe_d    = 1'b0;
            end
          end
        end
        S_ACK_P, S_ACK_W: begin
          if (scl_fall) begin
            state_d  = S_WDATA;
            bitcnt_d = '0;
            oe_d     = 1'b0;
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bitcnt_q == 4'd8) begin
              state_d  = S_RACK;
              bitcnt_d = '0;
              oe_d     = 1'b0;
              ptr_d    = ptr_q + 5'd1;
            end else begin
              oe_d    = ~shift_q[6];
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
        end
        S_RACK: begin
          // bitcnt marks that the initiator acknowledged; NACK ends the transfer at once
          if (scl_rise) begin
            if (sda_f_q) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end else begin
              bitcnt_d = 4'd1;
            end
          end else if (scl_fall && bitcnt_q == 4'd1) begin
            state_d  = S_RDATA;
            bitcnt_d = '0;
            shift_d  = rd_byte;
            oe_d     = ~rd_byte[7];
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state and output registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      ptr_q       <= '0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      ptr_q       <= ptr_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Register file with registered local read (old data on a same-cycle write)
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      loc_rd_q <= '0;
    end else begin
      if (reg_we) regs_q[ptr_q] <= shift_q;
      loc_rd_q <= regs_q[loc_addr];
    end
  end

endmodule

// File: tb/tb_smbus_responder.sv
// tb/tb_smbus_responder.sv - directed and randomized bus transactions against a register-file model
module tb_smbus_responder;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m, sda_m;
  logic       smb_sda_in;
  logic       smb_sda_oe;
  logic [4:0] loc_addr;
  logic [7:0] loc_rd_data;
  logic       wr_strobe;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  assign smb_sda_in = sda_m & ~smb_sda_oe;

  smbus_responder #(.DEV_ADDR(7'h48), .FILT(3)) dut (
    .ap_clk      (clk),
    .ap_rst_n    (rst_n),
    .smb_scl     (scl_m),
    .smb_sda_in  (smb_sda_in),
    .smb_sda_oe  (smb_sda_oe),
    .loc_addr    (loc_addr),
    .loc_rd_data (loc_rd_data),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // bus observers
  logic [12:0] strb_log [256];
  int strb_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strb_log[strb_cnt % 256] <= {wr_addr, wr_data};
      strb_cnt <= strb_cnt + 1;
    end
    if (smb_sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  // reference model
  logic [7:0]  mdl [32];
  int          mdl_ptr;
  logic [12:0] exp_strb [$];
  int          strb_rd = 0;
  logic [7:0]  wbuf [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(2*Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    b = smb_sda_in; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b1; wait_cyc(2*Q);
  endtask

  task automatic tx_byte(input string tag, input logic [7:0] d, input logic exp_ack_n);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(a);
    check(tag, {31'd0, a}, {31'd0, exp_ack_n});
  endtask

  task automatic rx_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic check_strobes(input string tag);
    check({tag, "_strb_cnt"}, 32'(strb_cnt - strb_rd), 32'(exp_strb.size()));
    foreach (exp_strb[i]) begin
      logic [12:0] got;
      got = (strb_rd + i < strb_cnt) ? strb_log[(strb_rd + i) % 256] : 13'h1fff;
      check({tag, "_strb"}, {19'd0, got}, {19'd0, exp_strb[i]});
    end
    strb_rd = strb_cnt;
    exp_strb.delete();
  endtask

  task automatic wr_txn(input string tag, input logic [7:0] p, input int n);
    bus_start();
    tx_byte({tag, "_ack_addr"}, 8'h90, 1'b0);
    tx_byte({tag, "_ack_ptr"}, p, 1'b0);
    mdl_ptr = int'(p[4:0]);
    for (int i = 0; i < n; i++) begin
      tx_byte({tag, "_ack_data"}, wbuf[i], 1'b0);
      mdl[mdl_ptr] = wbuf[i];
      exp_strb.push_back({5'(mdl_ptr), wbuf[i]});
      mdl_ptr = (mdl_ptr + 1) % 32;
    end
    bus_stop();
    wait_cyc(10);
    check_strobes(tag);
  endtask

  task automatic rd_txn(input string tag, input logic set_ptr, input logic [7:0] p, input int n);
    logic [7:0] d;
    bus_start();
    if (set_ptr) begin
      tx_byte({tag, "_ack_waddr"}, 8'h90, 1'b0);
      tx_byte({tag, "_ack_ptr"}, p, 1'b0);
      mdl_ptr = int'(p[4:0]);
      bus_start();
    end
    tx_byte({tag, "_ack_raddr"}, 8'h91, 1'b0);
    for (int i = 0; i < n; i++) begin
      rx_byte(i == n - 1, d);
      check({tag, "_rdata"}, {24'd0, d}, {24'd0, mdl[mdl_ptr]});
      mdl_ptr = (mdl_ptr + 1) % 32;
    end
    wait_cyc(10);
    check({tag, "_busy_nack"}, {31'd0, busy}, 32'd0);
    bus_stop();
    wait_cyc(10);
    check_strobes(tag);
  endtask

  task automatic loc_check(input string tag, input logic [4:0] a);
    loc_addr = a;
    wait_cyc(2);
    check(tag, {24'd0, loc_rd_data}, {24'd0, mdl[a]});
  endtask

  initial begin
    int oe0, busy0, strb0;
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; loc_addr = 5'd0;
    for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
    mdl_ptr = 0;
    wait_cyc(5);
    check("reset_oe", {31'd0, smb_sda_oe}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_strobe", {31'd0, wr_strobe}, 32'd0);
    check("reset_wr_addr_data", {19'd0, wr_addr, wr_data}, 32'd0);
    check("reset_loc_rd", {24'd0, loc_rd_data}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(10);

    // write burst
    wbuf[0] = 8'hA1; wbuf[1] = 8'hB2;
    wr_txn("wburst", 8'h05, 2);
    loc_check("wburst_loc6", 5'd6);
    check("wburst_loc6_const", {24'd0, loc_rd_data}, 32'hB2);

    // read burst with repeated START
    rd_txn("rburst", 1'b1, 8'h05, 2);

    // pointer wrap
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    wr_txn("wrap", 8'h1F, 3);
    loc_check("wrap_loc0", 5'd0);

    // address mismatch
    oe0 = oe_cnt; busy0 = busy_cnt; strb0 = strb_cnt;
    bus_start();
    tx_byte("mism_nack", 8'hA0, 1'b1);
    bus_stop();
    wait_cyc(10);
    check("mism_oe", 32'(oe_cnt - oe0), 32'd0);
    check("mism_busy", 32'(busy_cnt - busy0), 32'd0);
    check("mism_strobe", 32'(strb_cnt - strb0), 32'd0);

    // glitch rejection: a 1-cycle SDA low while SCL high must not start a transfer
    oe0 = oe_cnt; busy0 = busy_cnt;
    sda_m = 1'b0; wait_cyc(1);
    sda_m = 1'b1; wait_cyc(20);
    scl_m = 1'b0; wait_cyc(Q);
    tx_byte("glitch_nack", 8'h90, 1'b1);
    check("glitch_oe", 32'(oe_cnt - oe0), 32'd0);
    check("glitch_busy", 32'(busy_cnt - busy0), 32'd0);
    bus_stop();
    wait_cyc(10);

    // reset in the middle of a read while the responder is pulling SDA low
    bus_start();
    tx_byte("rstmid_ack_waddr", 8'h90, 1'b0);
    tx_byte("rstmid_ack_ptr", 8'h02, 1'b0);
    bus_start();
    tx_byte("rstmid_ack_raddr", 8'h91, 1'b0);
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    check("rstmid_pre_oe", {31'd0, smb_sda_oe}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rstmid_oe_async", {31'd0, smb_sda_oe}, 32'd0);
    wait_cyc(3);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    scl_m = 1'b1; sda_m = 1'b1;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(10);
    for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
    mdl_ptr = 0;
    exp_strb.delete();
    strb_rd = strb_cnt;
    for (int i = 0; i < 32; i++) loc_check("rstmid_regfile", 5'(i));

    // randomized transactions against the model
    for (int t = 0; t < 12; t++) begin
      int op, n;
      logic [7:0] p;
      op = (t == 0) ? 0 : int'($urandom_range(0, 2));
      n  = int'($urandom_range(1, 3));
      p  = 8'($urandom_range(0, 255));
      if (op == 0) begin
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
        wr_txn("rand_wr", p, n);
      end else if (op == 1) begin
        rd_txn("rand_rd_cont", 1'b0, 8'h00, n);
      end else begin
        rd_txn("rand_rd_ptr", 1'b1, p, n);
      end
      loc_check("rand_loc", 5'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
